hls_array_mem: RTL and testbench

Behavioural on-chip array that acts as the responder end of the kernel memory-argument protocol (`raddr_0/rdata_0`, `waddr_0/wdata_0/wen_0`, plus the `debug_*` side port). One instance per array argument of a generated kernel, e.g. the 4096×8 image array and the 256×32 bin array of the histogram kernel. Provides a 1-cycle registered read port, a write port, and a debug read/write port for testbench preload and readback. After reset it self-clears to zero before accepting traffic.

---
 rtl/hls_array_mem_if.sv | 30 +++
 rtl/hls_array_mem.sv | 120 ++++++++++++
 tb/tb_hls_array_mem.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hls_array_mem_if.sv
// Kernel memory-argument bus between a generated kernel (master) and hls_array_mem (slave).
// Carries the port-0 read/write channel, the debug side port and the init_done status.
interface hls_array_mem_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 8
);
    logic [ADDR_W-1:0] raddr_0;
    logic [WIDTH-1:0]  rdata_0;
    logic [ADDR_W-1:0] waddr_0;
    logic [WIDTH-1:0]  wdata_0;
    logic              wen_0;
    logic [ADDR_W-1:0] debug_addr;
    logic [WIDTH-1:0]  debug_data;
    logic [ADDR_W-1:0] debug_write_addr;
    logic [WIDTH-1:0]  debug_write_data;
    logic              debug_write_en;
    logic              init_done;

    modport master (
        output raddr_0, waddr_0, wdata_0, wen_0,
        output debug_addr, debug_write_addr, debug_write_data, debug_write_en,
        input  rdata_0, debug_data, init_done
    );

    modport slave (
        input  raddr_0, waddr_0, wdata_0, wen_0,
        input  debug_addr, debug_write_addr, debug_write_data, debug_write_en,
        output rdata_0, debug_data, init_done
    );
endinterface

// File: rtl/hls_array_mem.sv
// On-chip array responding to the kernel memory-argument protocol; self-clears after reset.
// Define HLS_ARRAY_MEM_BYPASS_EN to forward same-cycle write data to the read ports.
module hls_array_mem #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    hls_array_mem_if.slave bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;
    logic [WIDTH-1:0]  dbg_q, dbg_d;
    logic              init_done_q, init_done_d;
    logic              clr_we, p0_we, dbg_we;

    logic [WIDTH-1:0]  mem [DEPTH];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(a);
    endfunction

    // State, clear counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_addr_q  <= '0;
            rdata_q     <= '0;
            dbg_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            rdata_q     <= rdata_d;
            dbg_q       <= dbg_d;
            init_done_q <= init_done_d;
        end
    end

    // Next state, write enables and read mux
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        init_done_d = init_done_q;
        clr_we      = 1'b0;
        p0_we       = 1'b0;
        dbg_we      = 1'b0;
        rdata_d     = '0;
        dbg_d       = '0;

        case (state_q)
            CLEAR: begin
                clr_we     = !rst;
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d     = READY;
                    init_done_d = 1'b1;
                end
            end
            READY: begin
                p0_we  = !rst && bus.wen_0 && in_range(bus.waddr_0);
                dbg_we = !rst && bus.debug_write_en && in_range(bus.debug_write_addr);

                if (in_range(bus.raddr_0)) begin
                    rdata_d = mem[idx(bus.raddr_0)];
`ifdef HLS_ARRAY_MEM_BYPASS_EN
                    if (p0_we && (bus.waddr_0 == bus.raddr_0)) begin
                        rdata_d = bus.wdata_0;
                    end else if (dbg_we && (bus.debug_write_addr == bus.raddr_0)) begin
                        rdata_d = bus.debug_write_data;
                    end
`endif
                end

                if (in_range(bus.debug_addr)) begin
                    dbg_d = mem[idx(bus.debug_addr)];
`ifdef HLS_ARRAY_MEM_BYPASS_EN
                    if (p0_we && (bus.waddr_0 == bus.debug_addr)) begin
                        dbg_d = bus.wdata_0;
                    end else if (dbg_we && (bus.debug_write_addr == bus.debug_addr)) begin
                        dbg_d = bus.debug_write_data;
                    end
`endif
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Array storage; port 0 is written last so it wins a same-address collision
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[idx(clr_addr_q)] <= '0;
        end
        if (dbg_we) begin
            mem[idx(bus.debug_write_addr)] <= bus.debug_write_data;
        end
        if (p0_we) begin
            mem[idx(bus.waddr_0)] <= bus.wdata_0;
        end
    end

    assign bus.rdata_0    = rdata_q;
    assign bus.debug_data = dbg_q;
    assign bus.init_done  = init_done_q;

endmodule

// File: tb/tb_hls_array_mem.sv
// Scoreboard bench for hls_array_mem: a 256x32 instance and a 200x8 instance with 12-bit addresses.
module tb_hls_array_mem;
`ifdef HLS_ARRAY_MEM_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   checks = 0;
    int   errors = 0;

    exp_t q_ar[$], q_ad[$], q_br[$], q_bd[$];
    exp_t mon_e, push_e;
    logic a_r_iss, a_d_iss, b_r_iss, b_d_iss;
    logic f_ar, f_ad, f_br, f_bd;
    logic [31:0] v;

    always #5 clk = ~clk;

    hls_array_mem_if #(.WIDTH(32), .ADDR_W(8))  bus_a ();
    hls_array_mem_if #(.WIDTH(8),  .ADDR_W(12)) bus_b ();

    hls_array_mem #(.WIDTH(32), .DEPTH(256), .ADDR_W(8)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a.slave)
    );

    hls_array_mem #(.WIDTH(8), .DEPTH(200), .ADDR_W(12)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic a_next();
        @(negedge clk);
        bus_a.wen_0 = 1'b0;
        bus_a.debug_write_en = 1'b0;
        a_r_iss = 1'b0;
        a_d_iss = 1'b0;
    endtask

    task automatic a_rd(input logic [7:0] addr, input logic [31:0] exp, input string tag);
        bus_a.raddr_0 = addr;
        a_r_iss = 1'b1;
        push_e.tag = tag;
        push_e.exp = exp;
        q_ar.push_back(push_e);
    endtask

    task automatic a_drd(input logic [7:0] addr, input logic [31:0] exp, input string tag);
        bus_a.debug_addr = addr;
        a_d_iss = 1'b1;
        push_e.tag = tag;
        push_e.exp = exp;
        q_ad.push_back(push_e);
    endtask

    task automatic a_wr(input logic [7:0] addr, input logic [31:0] data);
        bus_a.waddr_0 = addr;
        bus_a.wdata_0 = data;
        bus_a.wen_0 = 1'b1;
    endtask

    task automatic a_dwr(input logic [7:0] addr, input logic [31:0] data);
        bus_a.debug_write_addr = addr;
        bus_a.debug_write_data = data;
        bus_a.debug_write_en = 1'b1;
    endtask

    task automatic b_next();
        @(negedge clk);
        bus_b.wen_0 = 1'b0;
        bus_b.debug_write_en = 1'b0;
        b_r_iss = 1'b0;
        b_d_iss = 1'b0;
    endtask

    task automatic b_rd(input logic [11:0] addr, input logic [31:0] exp, input string tag);
        bus_b.raddr_0 = addr;
        b_r_iss = 1'b1;
        push_e.tag = tag;
        push_e.exp = exp;
        q_br.push_back(push_e);
    endtask

    task automatic b_drd(input logic [11:0] addr, input logic [31:0] exp, input string tag);
        bus_b.debug_addr = addr;
        b_d_iss = 1'b1;
        push_e.tag = tag;
        push_e.exp = exp;
        q_bd.push_back(push_e);
    endtask

    task automatic b_wr(input logic [11:0] addr, input logic [7:0] data);
        bus_b.waddr_0 = addr;
        bus_b.wdata_0 = data;
        bus_b.wen_0 = 1'b1;
    endtask

    task automatic b_dwr(input logic [11:0] addr, input logic [7:0] data);
        bus_b.debug_write_addr = addr;
        bus_b.debug_write_data = data;
        bus_b.debug_write_en = 1'b1;
    endtask

    // Pop one expectation per issued read, one cycle after the address was presented
    always @(posedge clk) begin
        f_ar = a_r_iss;
        f_ad = a_d_iss;
        f_br = b_r_iss;
        f_bd = b_d_iss;
        #1;
        if (f_ar) begin
            if (q_ar.size() == 0) check("sb_ar_underflow", 32'(q_ar.size()), 32'd1);
            else begin mon_e = q_ar.pop_front(); check(mon_e.tag, bus_a.rdata_0, mon_e.exp); end
        end
        if (f_ad) begin
            if (q_ad.size() == 0) check("sb_ad_underflow", 32'(q_ad.size()), 32'd1);
            else begin mon_e = q_ad.pop_front(); check(mon_e.tag, bus_a.debug_data, mon_e.exp); end
        end
        if (f_br) begin
            if (q_br.size() == 0) check("sb_br_underflow", 32'(q_br.size()), 32'd1);
            else begin mon_e = q_br.pop_front(); check(mon_e.tag, 32'(bus_b.rdata_0), mon_e.exp); end
        end
        if (f_bd) begin
            if (q_bd.size() == 0) check("sb_bd_underflow", 32'(q_bd.size()), 32'd1);
            else begin mon_e = q_bd.pop_front(); check(mon_e.tag, 32'(bus_b.debug_data), mon_e.exp); end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        a_r_iss = 1'b0; a_d_iss = 1'b0; b_r_iss = 1'b0; b_d_iss = 1'b0;
        bus_a.raddr_0 = '0; bus_a.waddr_0 = '0; bus_a.wdata_0 = '0; bus_a.wen_0 = 1'b0;
        bus_a.debug_addr = '0; bus_a.debug_write_addr = '0; bus_a.debug_write_data = '0;
        bus_a.debug_write_en = 1'b0;
        bus_b.raddr_0 = '0; bus_b.waddr_0 = '0; bus_b.wdata_0 = '0; bus_b.wen_0 = 1'b0;
        bus_b.debug_addr = '0; bus_b.debug_write_addr = '0; bus_b.debug_write_data = '0;
        bus_b.debug_write_en = 1'b0;

        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // init_done low through the clear, high after the edge that clears word 255
        for (int k = 1; k <= 256; k++) begin
            @(posedge clk); #1;
            check("a_init_done", 32'(bus_a.init_done), 32'(k == 256));
            if (k == 1) check("a_rst_rdata", bus_a.rdata_0, 32'd0);
        end
        check("b_init_done", 32'(bus_b.init_done), 32'd1);

        a_next(); a_drd(8'd0,   32'd0, "idle_dbg0");
        a_next(); a_drd(8'd128, 32'd0, "idle_dbg128");
        a_next(); a_drd(8'd255, 32'd0, "idle_dbg255");

        a_next(); a_dwr(8'd5, 32'hDEADBEEF);
        a_next(); a_rd(8'd5, 32'hDEADBEEF, "dbgw_rd"); a_drd(8'd5, 32'hDEADBEEF, "dbgw_drd");

        a_next(); a_wr(8'd7, 32'h11); a_dwr(8'd7, 32'h22);
        a_next(); a_rd(8'd7, 32'h11, "same_addr_prio");
        a_next(); a_wr(8'd7, 32'h11); a_dwr(8'd8, 32'h22);
        a_next(); a_rd(8'd7, 32'h11, "dist_7"); a_drd(8'd8, 32'h22, "dist_8");

        a_next(); a_dwr(8'd3, 32'h10);
        a_next(); a_wr(8'd3, 32'h55); a_rd(8'd3, BYPASS ? 32'h55 : 32'h10, "rdw_p0");
        a_next(); a_rd(8'd3, 32'h55, "rdw_after");
        a_next(); a_dwr(8'd9, 32'h77); a_rd(8'd9, BYPASS ? 32'h77 : 32'h0, "rdw_dbg");
        a_next(); a_wr(8'd10, 32'hA1); a_dwr(8'd10, 32'hB2);
        a_drd(8'd10, BYPASS ? 32'hA1 : 32'h0, "rdw_prio");
        a_next(); a_rd(8'd10, 32'hA1, "prio_after");

        // Re-clear before the increment loop
        a_next(); rst_a = 1'b1;
        a_next(); rst_a = 1'b0;
        for (int k = 0; k < 300 && !bus_a.init_done; k++) begin
            @(posedge clk); #1;
        end
        check("a_reinit_done", 32'(bus_a.init_done), 32'd1);

        // Read in one stage, write rdata+1 in the next, II=2
        for (int p = 1; p <= 2; p++) begin
            for (int i = 0; i < 256; i++) begin
                a_next(); a_rd(8'(i), 32'(p - 1), "inc_rd");
                @(posedge clk); #1;
                v = bus_a.rdata_0;
                a_next(); a_wr(8'(i), v + 32'd1);
            end
        end
        for (int i = 0; i < 256; i++) begin
            a_next(); a_rd(8'(i), 32'd2, "inc_final"); a_drd(8'(255 - i), 32'd2, "inc_final_dbg");
        end
        a_next();

        b_next(); b_wr(12'd44, 8'h5A);
        b_next(); b_wr(12'd300, 8'hAA); b_dwr(12'd301, 8'hBB);
        b_next(); b_rd(12'd300, 32'h0, "oor_rd"); b_drd(12'd301, 32'h0, "oor_drd");
        b_next(); b_rd(12'd44, 32'h5A, "alias_44"); b_drd(12'd45, 32'h0, "alias_45");
        b_next(); b_wr(12'd199, 8'h33); b_dwr(12'd0, 8'hC3);
        b_next(); b_rd(12'd199, 32'h33, "last_word"); b_drd(12'd200, 32'h0, "first_oor");
        b_next(); b_rd(12'd0, 32'hC3, "word_0");

        // Mid-stream reset with a write pending
        b_next(); rst_b = 1'b1; b_wr(12'd1, 8'hEE); bus_b.raddr_0 = 12'd0;
        @(posedge clk); #1;
        check("b_rst_init", 32'(bus_b.init_done), 32'd0);
        check("b_rst_rdata", 32'(bus_b.rdata_0), 32'd0);
        b_next(); rst_b = 1'b0; bus_b.raddr_0 = 12'd199; bus_b.debug_addr = 12'd199;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            check("b_clr_init", 32'(bus_b.init_done), 32'(k == 200));
            check("b_clr_rdata", 32'(bus_b.rdata_0), 32'd0);
            check("b_clr_dbg", 32'(bus_b.debug_data), 32'd0);
            b_next();
            if (k == 100) b_dwr(12'd5, 8'h99);
            if (k == 150) b_wr(12'd7, 8'h77);
        end
        for (int i = 0; i < 200; i++) begin
            b_next(); b_rd(12'(i), 32'h0, "b_reclr"); b_drd(12'(199 - i), 32'h0, "b_reclr_dbg");
        end
        b_next();

        repeat (3) @(posedge clk);
        #2;
        check("sb_left", 32'(q_ar.size() + q_ad.size() + q_br.size() + q_bd.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
